// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if : row/column matrix lines plus accepted-key outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   modport slave (
      input  row,
      output col,
      output key,
      output key_valid,
      output key_held
   );

   modport master (
      output row,
      input  col,
      input  key,
      input  key_valid,
      input  key_held
   );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner : 4x4 matrix keypad scanner with press/release debounce
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module keypad_scanner #(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   keypad_scanner_if.slave kp
);

   localparam int              c_tick_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SCAN_DIV - 1);
   localparam logic [4:0]      c_deb       = 5'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_row_meta;
   logic [3:0]          r_row_sync;
   logic [c_tick_w-1:0] r_tick_cnt;
   logic [1:0]          r_col_idx;
   logic [1:0]          r_row_idx;
   logic [3:0]          r_match_cnt;
   logic [3:0]          r_rel_cnt;
   logic [3:0]          r_key;
   logic                r_key_valid;
   logic                r_key_held;

   logic                w_tick;
   logic                w_one_low;
   logic [1:0]          w_row_idx;
   logic [3:0]          w_cap_pat;
   logic [1:0]          w_col_idx_nxt;
   logic [1:0]          w_row_idx_nxt;
   logic [3:0]          w_match_nxt;
   logic [3:0]          w_rel_nxt;
   logic [3:0]          w_key_nxt;
   logic                w_valid_nxt;
   logic                w_held_nxt;

   function automatic logic [3:0] f_key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
      logic [3:0] v;
      case ({row_idx, col_idx})
         4'h0: v = 4'h1;
         4'h1: v = 4'h2;
         4'h2: v = 4'h3;
         4'h3: v = 4'hA;
         4'h4: v = 4'h4;
         4'h5: v = 4'h5;
         4'h6: v = 4'h6;
         4'h7: v = 4'hB;
         4'h8: v = 4'h7;
         4'h9: v = 4'h8;
         4'hA: v = 4'h9;
         4'hB: v = 4'hC;
         4'hC: v = 4'hE;
         4'hD: v = 4'h0;
         4'hE: v = 4'hF;
         default: v = 4'hD;
      endcase
      return v;
   endfunction

   assign w_tick    = (r_tick_cnt == c_tick_last);
   assign w_cap_pat = ~(4'b0001 << r_row_idx);

   // Multiple low rows are ambiguous (ghosting), so only a single low bit counts as a key.
   always_comb begin
      w_one_low = 1'b0;
      w_row_idx = 2'd0;
      case (r_row_sync)
         4'b1110: begin w_one_low = 1'b1; w_row_idx = 2'd0; end
         4'b1101: begin w_one_low = 1'b1; w_row_idx = 2'd1; end
         4'b1011: begin w_one_low = 1'b1; w_row_idx = 2'd2; end
         4'b0111: begin w_one_low = 1'b1; w_row_idx = 2'd3; end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_col_idx_nxt = r_col_idx;
      w_row_idx_nxt = r_row_idx;
      w_match_nxt   = r_match_cnt;
      w_rel_nxt     = r_rel_cnt;
      w_key_nxt     = r_key;
      w_valid_nxt   = 1'b0;
      w_held_nxt    = r_key_held;
      if (w_tick) begin
         case (r_state)
            ST_SCAN: begin
               if (w_one_low) begin
                  w_row_idx_nxt = w_row_idx;
                  w_match_nxt   = 4'd1;
                  w_state_nxt   = ST_DEBOUNCE;
               end else begin
                  w_col_idx_nxt = r_col_idx + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (r_row_sync == w_cap_pat) begin
                  if (({1'b0, r_match_cnt} + 5'd1) >= c_deb) begin
                     w_key_nxt   = f_key_map(r_row_idx, r_col_idx);
                     w_valid_nxt = 1'b1;
                     w_held_nxt  = 1'b1;
                     w_match_nxt = 4'd0;
                     w_state_nxt = ST_HELD;
                  end else begin
                     w_match_nxt = r_match_cnt + 4'd1;
                  end
               end else begin
                  w_match_nxt   = 4'd0;
                  w_col_idx_nxt = r_col_idx + 2'd1;
                  w_state_nxt   = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (r_row_sync == 4'hF) begin
                  if (c_deb <= 5'd1) begin
                     w_held_nxt    = 1'b0;
                     w_col_idx_nxt = r_col_idx + 2'd1;
                     w_state_nxt   = ST_SCAN;
                  end else begin
                     w_rel_nxt   = 4'd1;
                     w_state_nxt = ST_RELEASE;
                  end
               end
            end
            default: begin
               if (r_row_sync == 4'hF) begin
                  if (({1'b0, r_rel_cnt} + 5'd1) >= c_deb) begin
                     w_held_nxt    = 1'b0;
                     w_rel_nxt     = 4'd0;
                     w_col_idx_nxt = r_col_idx + 2'd1;
                     w_state_nxt   = ST_SCAN;
                  end else begin
                     w_rel_nxt = r_rel_cnt + 4'd1;
                  end
               end else begin
                  w_rel_nxt   = 4'd0;
                  w_state_nxt = ST_HELD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_SCAN;
         r_row_meta  <= 4'hF;
         r_row_sync  <= 4'hF;
         r_tick_cnt  <= '0;
         r_col_idx   <= 2'd0;
         r_row_idx   <= 2'd0;
         r_match_cnt <= 4'd0;
         r_rel_cnt   <= 4'd0;
         r_key       <= 4'h0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_row_meta  <= kp.row;
         r_row_sync  <= r_row_meta;
         r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + c_tick_w'(1);
         r_col_idx   <= w_col_idx_nxt;
         r_row_idx   <= w_row_idx_nxt;
         r_match_cnt <= w_match_nxt;
         r_rel_cnt   <= w_rel_nxt;
         r_key       <= w_key_nxt;
         r_key_valid <= w_valid_nxt;
         r_key_held  <= w_held_nxt;
      end
   end

   assign kp.col       = ~(4'b0001 << r_col_idx);
   assign kp.key       = r_key;
   assign kp.key_valid = r_key_valid;
   assign kp.key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner : directed bench with a switch-matrix keypad model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] press = 16'h0;
   logic [3:0]  row_m;

   always #5 clk = ~clk;

   keypad_scanner_if kp();

   keypad_scanner #(
      .SCAN_DIV (SCAN_DIV),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp.slave)
   );

   // A closed switch at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_m = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press[r*4+c] && !kp.col[c]) row_m[r] = 1'b0;
   end
   assign kp.row = row_m;

   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   n_pulse = 0;
   bit   dbl     = 1'b0;
   logic prev_v  = 1'b0;

   always @(negedge clk) begin
      if (kp.key_valid === 1'b1) n_pulse++;
      if (kp.key_valid === 1'b1 && prev_v === 1'b1) dbl = 1'b1;
      prev_v = kp.key_valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, expv);
      end
   endtask

   task automatic wait_col(input logic [3:0] c, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (kp.col === c) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (kp.key_valid === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_unheld(input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (kp.key_held === 1'b0) begin n = i; break; end
      end
   endtask

   task automatic run_seen(input int cycles, output logic [3:0] seen);
      seen = 4'h0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         case (kp.col)
            4'b1110: seen[0] = 1'b1;
            4'b1101: seen[1] = 1'b1;
            4'b1011: seen[2] = 1'b1;
            4'b0111: seen[3] = 1'b1;
            default: ;
         endcase
      end
   endtask

   initial begin
      bit         ok;
      int         n;
      int         p0;
      logic [3:0] seen;
      logic [3:0] exp_col;

      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_col",   kp.col,       4'b1110);
      check_eq("rst_key",   kp.key,       4'h0);
      check_eq("rst_valid", kp.key_valid, 1'b0);
      check_eq("rst_held",  kp.key_held,  1'b0);

      // Idle scan: full 4-cycle dwell per column starting at column 0
      p0    = n_pulse;
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
         check_eq("idle_col", kp.col, exp_col);
      end
      check_eq("idle_no_valid", n_pulse - p0, 0);

      // Steady press (r1,c2)
      p0 = n_pulse;
      press[1*4+2] = 1'b1;
      wait_valid(200, ok);
      check_eq("k6_timeout", ok, 1'b1);
      check_eq("k6_key",  kp.key,      4'h6);
      check_eq("k6_held", kp.key_held, 1'b1);
      repeat (30) @(negedge clk);
      check_eq("k6_one_pulse", n_pulse - p0, 1);
      check_eq("k6_col_frozen", kp.col, 4'b1011);
      press = 16'h0;
      wait_unheld(40, n);
      check_eq("k6_release_window", (n >= 11 && n <= 14), 1'b1);
      run_seen(20, seen);
      check_eq("k6_scan_resumes", seen, 4'hF);

      // Short press (r3,c1): two matching ticks then release
      p0 = n_pulse;
      wait_col(4'b1110, 40, ok);
      check_eq("short_col0_timeout", ok, 1'b1);
      press[3*4+1] = 1'b1;
      wait_col(4'b1101, 40, ok);
      check_eq("short_col1_timeout", ok, 1'b1);
      repeat (7) @(negedge clk);
      press = 16'h0;
      run_seen(20, seen);
      check_eq("short_no_valid", n_pulse - p0, 0);
      check_eq("short_key_kept", kp.key, 4'h6);
      check_eq("short_not_held", kp.key_held, 1'b0);
      check_eq("short_back_scan", seen[2], 1'b1);

      // Long hold (r0,c3) with a one-tick release bounce
      p0 = n_pulse;
      wait_col(4'b1110, 40, ok);
      press[0*4+3] = 1'b1;
      wait_valid(200, ok);
      check_eq("kA_timeout", ok, 1'b1);
      check_eq("kA_key", kp.key, 4'hA);
      repeat (100) @(negedge clk);
      check_eq("kA_one_pulse", n_pulse - p0, 1);
      press = 16'h0;
      repeat (4) @(negedge clk);
      press[0*4+3] = 1'b1;
      repeat (40) @(negedge clk);
      check_eq("kA_bounce_no_pulse", n_pulse - p0, 1);
      check_eq("kA_bounce_held", kp.key_held, 1'b1);
      check_eq("kA_bounce_key", kp.key, 4'hA);
      press = 16'h0;
      wait_unheld(40, n);
      check_eq("kA_release_timeout", (n > 0), 1'b1);

      // Two rows low on column 0: ambiguous, never captured
      p0 = n_pulse;
      press[0*4+0] = 1'b1;
      press[2*4+0] = 1'b1;
      run_seen(40, seen);
      check_eq("ghost_rotates", seen, 4'hF);
      check_eq("ghost_no_valid", n_pulse - p0, 0);
      check_eq("ghost_not_held", kp.key_held, 1'b0);
      check_eq("ghost_key_kept", kp.key, 4'hA);
      press = 16'h0;
      repeat (8) @(negedge clk);

      // Reset during debounce of (r2,c0), then hold through reset release
      p0 = n_pulse;
      wait_col(4'b0111, 40, ok);
      press[2*4+0] = 1'b1;
      wait_col(4'b1110, 40, ok);
      check_eq("rdeb_col0_timeout", ok, 1'b1);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rdeb_col",   kp.col,       4'b1110);
      check_eq("rdeb_key",   kp.key,       4'h0);
      check_eq("rdeb_valid", kp.key_valid, 1'b0);
      check_eq("rdeb_held",  kp.key_held,  1'b0);
      check_eq("rdeb_no_pulse", n_pulse - p0, 0);
      rst_n = 1'b1;
      wait_valid(100, ok);
      check_eq("k7_timeout", ok, 1'b1);
      check_eq("k7_key",  kp.key,      4'h7);
      check_eq("k7_held", kp.key_held, 1'b1);
      repeat (2) @(negedge clk);
      check_eq("k7_one_pulse", n_pulse - p0, 1);
      press = 16'h0;
      wait_unheld(40, n);
      check_eq("k7_release_timeout", (n > 0), 1'b1);

      check_eq("valid_never_back_to_back", dbl, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: Clock cycles per column dwell (one scan tick); legal range >= 4.
REQ-002 Parameter DEBOUNCE, default 4: consecutive matching tick samples needed to accept a press or release; legal range 1-15.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset; sampled on the Clock rising edge.
REQ-005 ROW  input  4  keypad row lines, active-low (idle 4'b1111), asynchronous to Clock.
REQ-006 COL  output  4  keypad column drive, active-low one-hot (exactly one bit 0 at all times).
REQ-007 KEY  output  4  hex code of the last accepted key; held until the next accepted key.
REQ-008 KEY_VALID  output  1  one-cycle pulse when a new key is accepted.
REQ-009 KEY_HELD  output  1  high from the KEY_VALID cycle until release is accepted.

Function
REQ-010 ROW SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rs).
REQ-011 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; the tick fires on the cycle the count equals SCAN_DIV-1.
REQ-012 States: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: on each tick, if rs has exactly one bit low, capture the row index and the column index and go to DEBOUNCE with match count 1; otherwise rotate COL to the next column (1110->1101->1011->0111->1110).
REQ-014 SCAN with two or more rs bits low SHALL be treated as no key: rotate COL, no capture.
REQ-015 DEBOUNCE: COL frozen; on each tick, if rs equals the captured pattern, increment the match count, else return to SCAN and rotate COL.
REQ-016 When the match count reaches DEBOUNCE, the FSM SHALL update KEY, pulse KEY_VALID for exactly one cycle (the cycle after that tick), set KEY_HELD, and go to HELD; with DEBOUNCE=1 this happens on the tick following capture.
REQ-017 Key map (row,col) -> KEY: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E,0,F,D (E='*', F='#').
REQ-018 HELD: COL frozen; on a tick with rs == 4'b1111, go to RELEASE with release count 1; otherwise stay. No further KEY_VALID while held (no auto-repeat).
REQ-019 RELEASE: on each tick, rs == 4'b1111 increments the release count, anything else returns to HELD; when the count reaches DEBOUNCE, clear KEY_HELD, rotate COL, and go to SCAN.
REQ-020 A second key pressed on another column while HELD SHALL be ignored; a second key on the same column keeps HELD (rs != 1111).
REQ-021 KEY_VALID SHALL never be high for two consecutive cycles.
REQ-022 Counters SHALL be sized to hold their maximum value without overflow; the match and release counts are 4 bits.

Reset
REQ-023 While Reset == 0 at a Clock edge: state=SCAN, COL=4'b1110, KEY=4'h0, KEY_VALID=0, KEY_HELD=0, all counters and synchronizer flops cleared (synchronizer to 1111).
REQ-024 Reset asserted mid-DEBOUNCE/HELD/RELEASE SHALL abort the operation with no KEY_VALID pulse; after release, scanning restarts at column 0 with a full SCAN_DIV dwell.

Verification (SCAN_DIV=4, DEBOUNCE=3)
REQ-025 No key pressed for 40 cycles after reset -> COL cycles 1110,1101,1011,0111 every 4 cycles; KEY_VALID stays 0.
REQ-026 Press (r1,c2) steadily -> KEY=4'h6, a single 1-cycle KEY_VALID, KEY_HELD=1; release it -> KEY_HELD=0 after 3 idle ticks, scanning resumes.
REQ-027 Press (r3,c1) for only 2 ticks, then release -> no KEY_VALID, KEY unchanged, FSM returns to SCAN.
REQ-028 Hold (r0,c3) for 100 cycles -> exactly one KEY_VALID with KEY=4'hA; a release bounce of 1 tick then re-press -> still no second pulse.
REQ-029 Rows r0 and r2 low together on c0 -> no capture, COL keeps rotating, no KEY_VALID.
REQ-030 Reset pulsed low during DEBOUNCE of (r2,c0) -> outputs at reset values, no KEY_VALID; after reset, holding the key yields KEY=4'h7.
